euler_writeback_stage: RTL and testbench

//  Write-side end of the Euler matrix-vector pipeline: consumes the product stream from the mul stage.

---
 rtl/euler_writeback_stage_pkg.sv | 17 +
 rtl/euler_writeback_stage_sat_update.sv | 56 +++++
 rtl/euler_writeback_stage.sv | 184 ++++++++++++++++++
 tb/tb_euler_writeback_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/euler_writeback_stage_pkg.sv
// Shared definitions for the Euler write-back stage.
//   wb_state_e       : FSM state encoding
//   DefaultFracBits  : default Q-format fractional bits of the step size
package euler_writeback_stage_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAccum  = 3'd1,
        StReadX  = 3'd2,
        StUpdate = 3'd3,
        StWrite  = 3'd4,
        StDone   = 3'd5
    } wb_state_e;

    localparam int unsigned DefaultFracBits = 8;

endpackage

// File: rtl/euler_writeback_stage_sat_update.sv
// Combinational Euler update: sum = sat(x_old + sat((sat(acc) * h) >>> FRAC_BITS)).
//   i_acc    : wide signed dot-product accumulator
//   i_x_old  : previous state value x_old[row]
//   i_step_h : signed step size with FRAC_BITS fractional bits
//   o_sum    : saturated x_new[row]
//   o_ovf    : high when any of the three stages clamped
module euler_writeback_stage_sat_update
    import euler_writeback_stage_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned ACC_SIZE  = 22,
    parameter int unsigned FRAC_BITS = DefaultFracBits
) (
    input  logic signed [ACC_SIZE-1:0]  i_acc,
    input  logic signed [DATA_SIZE-1:0] i_x_old,
    input  logic signed [DATA_SIZE-1:0] i_step_h,
    output logic signed [DATA_SIZE-1:0] o_sum,
    output logic                        o_ovf
);

    localparam int unsigned ProdW = 2 * DATA_SIZE;
    localparam int unsigned SumW  = DATA_SIZE + 1;

    localparam logic signed [DATA_SIZE-1:0] SatMax = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [DATA_SIZE-1:0] SatMin = {1'b1, {(DATA_SIZE-1){1'b0}}};

    logic                        w_acc_fits;
    logic signed [DATA_SIZE-1:0] w_acc_sat;
    logic signed [ProdW-1:0]     w_prod;
    logic signed [ProdW-1:0]     w_prod_shift;
    logic                        w_p_fits;
    logic signed [DATA_SIZE-1:0] w_p_sat;
    logic signed [SumW-1:0]      w_sum_full;
    logic                        w_sum_fits;

    // A value fits in DATA_SIZE bits when everything above the new sign bit is a sign copy.
    assign w_acc_fits = (i_acc[ACC_SIZE-1:DATA_SIZE-1] ==
                         {(ACC_SIZE-DATA_SIZE+1){i_acc[ACC_SIZE-1]}});
    assign w_acc_sat  = w_acc_fits ? i_acc[DATA_SIZE-1:0] :
                        (i_acc[ACC_SIZE-1] ? SatMin : SatMax);

    assign w_prod       = ProdW'(w_acc_sat) * ProdW'(i_step_h);
    assign w_prod_shift = w_prod >>> FRAC_BITS;
    assign w_p_fits     = (w_prod_shift[ProdW-1:DATA_SIZE-1] ==
                           {(ProdW-DATA_SIZE+1){w_prod_shift[ProdW-1]}});
    assign w_p_sat      = w_p_fits ? w_prod_shift[DATA_SIZE-1:0] :
                          (w_prod_shift[ProdW-1] ? SatMin : SatMax);

    assign w_sum_full = SumW'(i_x_old) + SumW'(w_p_sat);
    assign w_sum_fits = (w_sum_full[SumW-1] == w_sum_full[SumW-2]);
    assign o_sum      = w_sum_fits ? w_sum_full[DATA_SIZE-1:0] :
                        (w_sum_full[SumW-1] ? SatMin : SatMax);

    assign o_ovf = !w_acc_fits || !w_p_fits || !w_sum_fits;

endmodule

// File: rtl/euler_writeback_stage.sv
// Write-side end of the Euler matrix-vector pipeline. Accumulates one dot product per row
// from the product stream, reads x_old[row], writes x_new[row] = x_old + h*acc.
//   i_clk/i_rst_n          : clock, asynchronous active-low reset
//   i_start, i_shape_*     : begin one step; rows/columns latched on accepted start
//   i_step_h               : signed step size (FRAC_BITS fractional bits)
//   i_prod_valid/_data     : product stream; o_prod_ready high only while accumulating
//   o_x_rd_en/_addr        : one-cycle read of x_old; i_x_rd_data valid one cycle later
//   o_wr_en/_addr/_data    : one write per row
//   o_row_done/final_done  : per-row and end-of-step pulses
//   o_busy, o_overflow     : not idle; sticky saturation flag cleared on accepted start
module euler_writeback_stage
    import euler_writeback_stage_pkg::*;
#(
    parameter int unsigned ADD_SIZE  = 16,
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned MAX_DIM   = 6,
    parameter int unsigned FRAC_BITS = DefaultFracBits,
    parameter int unsigned X_BASE    = 0,
    parameter int unsigned WR_BASE   = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [MAX_DIM-1:0]          i_shape_0,
    input  logic [MAX_DIM-1:0]          i_shape_1,
    input  logic signed [DATA_SIZE-1:0] i_step_h,
    input  logic                        i_prod_valid,
    input  logic signed [DATA_SIZE-1:0] i_prod_data,
    output logic                        o_prod_ready,
    output logic                        o_x_rd_en,
    output logic [ADD_SIZE-1:0]         o_x_rd_addr,
    input  logic signed [DATA_SIZE-1:0] i_x_rd_data,
    output logic                        o_wr_en,
    output logic [ADD_SIZE-1:0]         o_wr_addr,
    output logic signed [DATA_SIZE-1:0] o_wr_data,
    output logic                        o_row_done,
    output logic                        o_final_done,
    output logic                        o_busy,
    output logic                        o_overflow
);

    localparam int unsigned AccW = DATA_SIZE + MAX_DIM;

    wb_state_e                   r_state;
    logic [MAX_DIM-1:0]          r_shape_0;
    logic [MAX_DIM-1:0]          r_shape_1;
    logic [MAX_DIM-1:0]          r_row;
    logic [MAX_DIM-1:0]          r_col;
    logic signed [DATA_SIZE-1:0] r_step_h;
    logic signed [AccW-1:0]      r_acc;
    logic                        r_x_rd_en;
    logic [ADD_SIZE-1:0]         r_x_rd_addr;
    logic                        r_wr_en;
    logic [ADD_SIZE-1:0]         r_wr_addr;
    logic signed [DATA_SIZE-1:0] r_wr_data;
    logic                        r_row_done;
    logic                        r_final_done;
    logic                        r_overflow;

    logic                        w_col_last;
    logic                        w_row_last;
    logic signed [AccW-1:0]      w_prod_ext;
    logic [ADD_SIZE-1:0]         w_rd_addr;
    logic [ADD_SIZE-1:0]         w_wr_addr;
    logic signed [DATA_SIZE-1:0] w_sum;
    logic                        w_ovf;

    assign w_col_last = (r_col == (r_shape_1 - MAX_DIM'(1)));
    assign w_row_last = (r_row == (r_shape_0 - MAX_DIM'(1)));
    assign w_prod_ext = {{MAX_DIM{i_prod_data[DATA_SIZE-1]}}, i_prod_data};
    assign w_rd_addr  = ADD_SIZE'(X_BASE) + ADD_SIZE'(r_row);
    assign w_wr_addr  = ADD_SIZE'(WR_BASE) + ADD_SIZE'(r_row);

    euler_writeback_stage_sat_update #(
        .DATA_SIZE (DATA_SIZE),
        .ACC_SIZE  (AccW),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat_update (
        .i_acc    (r_acc),
        .i_x_old  (i_x_rd_data),
        .i_step_h (r_step_h),
        .o_sum    (w_sum),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_shape_0    <= '0;
            r_shape_1    <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_step_h     <= '0;
            r_acc        <= '0;
            r_x_rd_en    <= 1'b0;
            r_x_rd_addr  <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_row_done   <= 1'b0;
            r_final_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // Strobes are single-cycle; the transitions below re-arm them.
            r_x_rd_en    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_row_done   <= 1'b0;
            r_final_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_shape_0  <= i_shape_0;
                        r_shape_1  <= i_shape_1;
                        r_step_h   <= i_step_h;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_acc      <= '0;
                        r_overflow <= 1'b0;
                        if (i_shape_0 == '0 || i_shape_1 == '0) begin
                            r_state      <= StDone;
                            r_final_done <= 1'b1;
                        end else begin
                            r_state <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (i_prod_valid) begin
                        r_acc <= r_acc + w_prod_ext;
                        if (w_col_last) begin
                            r_col       <= '0;
                            r_state     <= StReadX;
                            r_x_rd_en   <= 1'b1;
                            r_x_rd_addr <= w_rd_addr;
                        end else begin
                            r_col <= r_col + MAX_DIM'(1);
                        end
                    end
                end
                StReadX: begin
                    r_state <= StUpdate;
                end
                StUpdate: begin
                    r_wr_data  <= w_sum;
                    r_wr_addr  <= w_wr_addr;
                    r_wr_en    <= 1'b1;
                    r_row_done <= 1'b1;
                    if (w_ovf) begin
                        r_overflow <= 1'b1;
                    end
                    r_state <= StWrite;
                end
                StWrite: begin
                    r_acc <= '0;
                    if (w_row_last) begin
                        r_state      <= StDone;
                        r_final_done <= 1'b1;
                    end else begin
                        r_row   <= r_row + MAX_DIM'(1);
                        r_state <= StAccum;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_prod_ready = (r_state == StAccum);
    assign o_busy       = (r_state != StIdle);
    assign o_x_rd_en    = r_x_rd_en;
    assign o_x_rd_addr  = r_x_rd_addr;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_row_done   = r_row_done;
    assign o_final_done = r_final_done;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_euler_writeback_stage.sv
// Scoreboard bench for euler_writeback_stage: expected writes are queued by the stimulus,
// a negedge monitor pops and compares on every wr_en.
module tb_euler_writeback_stage;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  shape_0;
    logic [5:0]  shape_1;
    logic [15:0] step_h;
    logic        prod_valid;
    logic [15:0] prod_data;
    logic        prod_ready;
    logic        x_rd_en;
    logic [15:0] x_rd_addr;
    logic [15:0] x_rd_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        row_done;
    logic        final_done;
    logic        busy;
    logic        overflow;

    logic [15:0] xmem [0:63];
    wr_exp_t     exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_row_done = 0;
    int          n_final = 0;

    euler_writeback_stage dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_shape_0    (shape_0),
        .i_shape_1    (shape_1),
        .i_step_h     (step_h),
        .i_prod_valid (prod_valid),
        .i_prod_data  (prod_data),
        .o_prod_ready (prod_ready),
        .o_x_rd_en    (x_rd_en),
        .o_x_rd_addr  (x_rd_addr),
        .i_x_rd_data  (x_rd_data),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_row_done   (row_done),
        .o_final_done (final_done),
        .o_busy       (busy),
        .o_overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector memory with one-cycle read latency.
    always @(posedge clk) begin
        if (x_rd_en) x_rd_data <= xmem[x_rd_addr[5:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write is popped and compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                         wr_addr, wr_data);
            end else begin
                wr_exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
            chk("row_done_with_wr", {30'd0, row_done, prod_ready}, 32'd2);
        end
        if (row_done) n_row_done++;
        if (final_done) n_final++;
    end

    task automatic do_start(input logic [5:0] s0, input logic [5:0] s1, input logic [15:0] h);
        start = 1'b1; shape_0 = s0; shape_1 = s1; step_h = h;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [15:0] d, input bit gap);
        int t = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        while (!prod_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("prod_ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
        prod_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic wait_final(input string name);
        int t = 0;
        while (!final_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_final_seen"}, 32'(final_done), 32'd1);
        @(negedge clk);
        chk({name, "_idle_after"}, {30'd0, final_done, busy}, 32'd0);
    endtask

    initial begin
        int rd0;
        int fd0;
        rst_n = 1'b0; start = 1'b0; shape_0 = '0; shape_1 = '0; step_h = '0;
        prod_valid = 1'b0; prod_data = '0; x_rd_data = '0;
        for (int i = 0; i < 64; i++) xmem[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {23'd0, prod_ready, x_rd_en, wr_en, row_done, final_done, busy,
                              overflow, 2'b00}, 32'd0);
        chk("reset_data", {wr_data, wr_addr | x_rd_addr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic 2x2, h=1.0, with latency checks on row 0
        xmem[0] = 16'd1; xmem[1] = 16'd2;
        exp_q.push_back('{16'd0, 16'd8});
        exp_q.push_back('{16'd1, 16'd13});
        rd0 = n_row_done; fd0 = n_final;
        do_start(6'd2, 6'd2, 16'h0100);
        chk("t1_busy", 32'(busy), 32'd1);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        chk("t1_rd_strobe", {15'd0, x_rd_en, x_rd_addr}, {15'd0, 1'b1, 16'd0});
        @(negedge clk);
        chk("t1_wr_not_yet", {30'd0, wr_en, x_rd_en}, 32'd0);
        @(negedge clk);
        chk("t1_wr_latency", 32'(wr_en), 32'd1);
        @(negedge clk);
        chk("t1_ready_after_wr", 32'(prod_ready), 32'd1);
        send(16'd5, 1'b0);
        send(16'd6, 1'b0);
        wait_final("t1");
        chk("t1_row_done_cnt", 32'(n_row_done - rd0), 32'd2);
        chk("t1_final_cnt", 32'(n_final - fd0), 32'd1);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_overflow", 32'(overflow), 32'd0);

        // 2: same step with valid gaps
        exp_q.push_back('{16'd0, 16'd8});
        exp_q.push_back('{16'd1, 16'd13});
        do_start(6'd2, 6'd2, 16'h0100);
        send(16'd3, 1'b1);
        chk("t2_ready_outside", 32'(prod_ready), 32'd1);
        send(16'd4, 1'b1);
        chk("t2_ready_low_rdx", 32'(prod_ready), 32'd0);
        send(16'd5, 1'b1);
        send(16'd6, 1'b1);
        wait_final("t2");
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: saturation, 1x1
        xmem[0] = 16'h1000;
        exp_q.push_back('{16'd0, 16'h7FFF});
        do_start(6'd1, 6'd1, 16'h0200);
        send(16'h7000, 1'b0);
        wait_final("t3");
        chk("t3_overflow", 32'(overflow), 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_overflow_held", 32'(overflow), 32'd1);

        // 4: zero rows
        fd0 = n_final;
        do_start(6'd0, 6'd3, 16'h0100);
        chk("t4_done_state", {29'd0, final_done, busy, overflow}, 32'd6);
        @(negedge clk);
        chk("t4_idle", {30'd0, final_done, busy}, 32'd0);
        chk("t4_final_cnt", 32'(n_final - fd0), 32'd1);

        // 5: reset during row 1, then a clean step
        xmem[0] = 16'd1; xmem[1] = 16'd2;
        exp_q.push_back('{16'd0, 16'd8});
        do_start(6'd2, 6'd2, 16'h0100);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        send(16'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outputs", {25'd0, prod_ready, x_rd_en, wr_en, row_done, final_done, busy,
                                 overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_still_idle", {30'd0, busy, wr_en}, 32'd0);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
        exp_q.push_back('{16'd0, 16'd8});
        exp_q.push_back('{16'd1, 16'd13});
        do_start(6'd2, 6'd2, 16'h0100);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        send(16'd5, 1'b0);
        send(16'd6, 1'b0);
        wait_final("t5");
        chk("t5_q_empty2", 32'(exp_q.size()), 32'd0);

        // 6: start ignored mid-step; h = -0.5
        xmem[0] = 16'd20; xmem[1] = 16'hFFFA;
        exp_q.push_back('{16'd0, 16'd15});
        exp_q.push_back('{16'd1, 16'hFFFC});
        rd0 = n_row_done;
        do_start(6'd2, 6'd2, 16'hFF80);
        send(16'd4, 1'b0);
        do_start(6'd1, 6'd1, 16'h0100);
        send(16'd6, 1'b0);
        send(16'hFFFE, 1'b0);
        send(16'hFFFE, 1'b0);
        wait_final("t6");
        chk("t6_row_done_cnt", 32'(n_row_done - rd0), 32'd2);
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
